// File: rtl/element_update_feeder.sv
// Upstream feeder for the matrix solver core: buffers host element updates in a
// FIFO and issues them to the core one at a time, waiting for EOC between issues.
module element_update_feeder #(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned MATRIX_N       = 256,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_x,
  input  logic [15:0]              in_y,
  input  logic [47:0]              in_elem,
  output logic [15:0]              X,
  output logic [15:0]              Y,
  output logic [47:0]              NewElement,
  output logic                     EnableChange,
  input  logic                     EOC_Flag,
  output logic                     busy,
  output logic                     err_drop,
  output logic                     err_timeout,
  output logic [15:0]              done_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [47:0] elem;
  } entry_t;

  typedef enum logic {IDLE, WAIT} state_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   count;
  logic [LW-1:0]   count_next;
  logic            accept;
  logic            in_range;
  logic            push;
  logic            pop;
  logic            eoc_q;
  logic            eoc_rise;
  logic [TW-1:0]   timer;
  state_t          state;

  assign accept   = in_valid && in_ready;
  assign in_range = (32'(in_x) < MATRIX_N) && (32'(in_y) < MATRIX_N);
  assign push     = accept && in_range;
  assign pop      = (state == IDLE) && (count != '0);
  assign head     = mem[rd_ptr];
  assign eoc_rise = EOC_Flag && !eoc_q;
  assign fifo_level = count;

  // Occupancy after this cycle's push/pop; also drives the registered ready.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + LW'(1);
      2'b01:   count_next = count - LW'(1);
      default: count_next = count;
    endcase
  end

  // Storage has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= '{x: in_x, y: in_y, elem: in_elem};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b1;
      err_drop <= 1'b0;
      eoc_q    <= 1'b0;
    end else begin
      eoc_q    <= EOC_Flag;
      err_drop <= accept && !in_range;
      count    <= count_next;
      in_ready <= (count_next != LW'(DEPTH));
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Issue/wait sequencer. EnableChange is high only in the issue cycle, so it
  // doubles as the marker for ignoring an EOC rise that coincides with issue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      X            <= '0;
      Y            <= '0;
      NewElement   <= '0;
      EnableChange <= 1'b0;
      busy         <= 1'b0;
      err_timeout  <= 1'b0;
      done_count   <= '0;
      timer        <= '0;
    end else begin
      EnableChange <= 1'b0;
      err_timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            X            <= head.x;
            Y            <= head.y;
            NewElement   <= head.elem;
            EnableChange <= 1'b1;
            busy         <= 1'b1;
            timer        <= '0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          // Completion is tested first so it wins a tie with the timeout.
          if (eoc_rise && !EnableChange) begin
            done_count <= done_count + 16'd1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (timer == TW'(TIMEOUT_CYCLES)) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_element_update_feeder.sv
// Directed bench for element_update_feeder: handshake, issue order, range drop,
// timeout, EOC/timeout race and asynchronous reset.
module tb_element_update_feeder;

  localparam int unsigned DEPTH    = 8;
  localparam int unsigned MATRIX_N = 256;
  localparam int unsigned TMO      = 20;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic [47:0] in_elem;
  logic [15:0] X;
  logic [15:0] Y;
  logic [47:0] NewElement;
  logic        EnableChange;
  logic        EOC_Flag;
  logic        busy;
  logic        err_drop;
  logic        err_timeout;
  logic [15:0] done_count;
  logic [3:0]  fifo_level;

  element_update_feeder #(
    .DEPTH(DEPTH),
    .MATRIX_N(MATRIX_N),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_x(in_x),
    .in_y(in_y),
    .in_elem(in_elem),
    .X(X),
    .Y(Y),
    .NewElement(NewElement),
    .EnableChange(EnableChange),
    .EOC_Flag(EOC_Flag),
    .busy(busy),
    .err_drop(err_drop),
    .err_timeout(err_timeout),
    .done_count(done_count),
    .fifo_level(fifo_level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks;
  int n_fail;
  int n_issue;
  int n_drop;
  int n_tmo;
  logic [15:0] issued_x [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Log every issue strobe and error pulse while out of reset.
  always @(negedge clock) begin
    if (reset) begin
      if (EnableChange) begin
        n_issue++;
        issued_x.push_back(X);
      end
      if (err_drop)    n_drop++;
      if (err_timeout) n_tmo++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_one(input logic [15:0] x, input logic [15:0] y, input logic [47:0] e);
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_elem  = e;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_issue(input string tag);
    int k;
    k = 0;
    while (!EnableChange && k < 50) begin
      step();
      k++;
    end
    check(tag, 64'(EnableChange), 64'd1);
  endtask

  // Raise EOC two cycles after the issue cycle for one cycle.
  task automatic finish_current();
    step();
    step();
    EOC_Flag = 1'b1;
    step();
    EOC_Flag = 1'b0;
  endtask

  task automatic wait_timeout(output int k);
    k = 0;
    while (!err_timeout && k < 40) begin
      step();
      k++;
    end
  endtask

  int base;
  int base_drop;
  int k;
  int exp_done;

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_x     = '0;
    in_y     = '0;
    in_elem  = '0;
    EOC_Flag = 1'b0;
    exp_done = 0;

    #12;
    check("rst_x",     64'(X), 64'd0);
    check("rst_en",    64'(EnableChange), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(done_count), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    @(negedge clock);
    reset = 1'b1;
    step();

    // Single update: accept at cycle 0, strobe at cycle 2.
    push_one(16'd3, 16'd5, 48'h3F8000_000000);
    check("t1_level1", 64'(fifo_level), 64'd1);
    check("t1_en_c1",  64'(EnableChange), 64'd0);
    step();
    check("t1_en_c2",  64'(EnableChange), 64'd1);
    check("t1_x",      64'(X), 64'd3);
    check("t1_y",      64'(Y), 64'd5);
    check("t1_elem",   64'(NewElement), 64'h3F8000_000000);
    check("t1_busy",   64'(busy), 64'd1);
    check("t1_level0", 64'(fifo_level), 64'd0);
    step();
    check("t1_en_width", 64'(EnableChange), 64'd0);
    check("t1_busy_w",   64'(busy), 64'd1);
    tick(8);
    EOC_Flag = 1'b1;
    step();
    exp_done++;
    check("t1_busy_done", 64'(busy), 64'd0);
    check("t1_done",      64'(done_count), 64'(exp_done));
    EOC_Flag = 1'b0;
    step();
    check("t1_x_hold", 64'(X), 64'd3);

    // Out-of-range requests are consumed and dropped; 255 is still legal.
    base      = n_issue;
    base_drop = n_drop;
    push_one(16'd256, 16'd0, 48'h1);
    check("rng_drop_x",  64'(err_drop), 64'd1);
    check("rng_level",   64'(fifo_level), 64'd0);
    push_one(16'd0, 16'd300, 48'h2);
    check("rng_drop_y",  64'(err_drop), 64'd1);
    step();
    check("rng_drop_lo", 64'(err_drop), 64'd0);
    tick(3);
    check("rng_no_issue", 64'(n_issue - base), 64'd0);
    check("rng_drops",    64'(n_drop - base_drop), 64'd2);
    push_one(16'd255, 16'd255, 48'h3);
    wait_issue("rng_255_issue");
    check("rng_255_x", 64'(X), 64'd255);
    finish_current();
    exp_done++;

    // Fill the FIFO while the first entry waits for EOC.
    base = n_issue;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_x     = 16'(20 + i);
      in_y     = 16'(i);
      in_elem  = 48'(i);
      step();
      if (i == 0) check("fill_lvl_first", 64'(fifo_level), 64'd1);
      if (i == 1) check("fill_lvl_pushpop", 64'(fifo_level), 64'd1);
      if (i == 7) begin
        check("fill_lvl7", 64'(fifo_level), 64'd7);
        check("fill_ready7", 64'(in_ready), 64'd1);
      end
      if (i == 8) begin
        check("fill_lvl8", 64'(fifo_level), 64'd8);
        check("fill_ready8", 64'(in_ready), 64'd0);
      end
    end
    in_x = 16'd99;
    step();
    in_valid = 1'b0;
    check("fill_no_passthru", 64'(fifo_level), 64'd8);
    EOC_Flag = 1'b1;
    step();
    EOC_Flag = 1'b0;
    exp_done++;
    for (int i = 1; i < 9; i++) begin
      wait_issue("fill_issue");
      finish_current();
      exp_done++;
    end
    step();
    check("fill_issues", 64'(n_issue - base), 64'd9);
    for (int i = 0; i < 9; i++) begin
      if (base + i < issued_x.size())
        check("fill_order", 64'(issued_x[base + i]), 64'(20 + i));
    end
    check("fill_done",  64'(done_count), 64'(exp_done));
    check("fill_empty", 64'(fifo_level), 64'd0);
    check("fill_no_tmo", 64'(n_tmo), 64'd0);

    // Timeout: timer reaches TMO at issue+TMO, pulse visible one edge later.
    push_one(16'd7, 16'd1, 48'h7);
    push_one(16'd8, 16'd1, 48'h8);
    wait_issue("tmo_issue");
    check("tmo_x", 64'(X), 64'd7);
    wait_timeout(k);
    check("tmo_lat",   64'(k), 64'(TMO + 1));
    check("tmo_pulse", 64'(err_timeout), 64'd1);
    check("tmo_busy",  64'(busy), 64'd0);
    check("tmo_done",  64'(done_count), 64'(exp_done));
    step();
    check("tmo_pulse_lo", 64'(err_timeout), 64'd0);
    check("tmo_next_en",  64'(EnableChange), 64'd1);
    check("tmo_next_x",   64'(X), 64'd8);

    // Race: EOC rises on the cycle the timer reaches TMO.
    tick(TMO);
    check("race_busy", 64'(busy), 64'd1);
    EOC_Flag = 1'b1;
    step();
    exp_done++;
    check("race_done",  64'(done_count), 64'(exp_done));
    check("race_no_tmo", 64'(err_timeout), 64'd0);
    check("race_busy0", 64'(busy), 64'd0);
    step();
    check("race_no_tmo2", 64'(err_timeout), 64'd0);

    // EOC stuck high gives no rise, so the next update times out.
    push_one(16'd9, 16'd9, 48'h9);
    wait_issue("stuck_issue");
    wait_timeout(k);
    check("stuck_tmo",  64'(err_timeout), 64'd1);
    check("stuck_lat",  64'(k), 64'(TMO + 1));
    check("stuck_done", 64'(done_count), 64'(exp_done));
    EOC_Flag = 1'b0;
    step();

    // Asynchronous reset mid-WAIT with three entries queued.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_x    = 16'(10 + i);
      in_y    = 16'd0;
      in_elem = 48'(i);
      step();
    end
    in_valid = 1'b0;
    check("rstm_level", 64'(fifo_level), 64'd3);
    check("rstm_busy",  64'(busy), 64'd1);
    #3;
    reset = 1'b0;
    #1;
    check("rstm_x",     64'(X), 64'd0);
    check("rstm_y",     64'(Y), 64'd0);
    check("rstm_elem",  64'(NewElement), 64'd0);
    check("rstm_busy0", 64'(busy), 64'd0);
    check("rstm_lvl0",  64'(fifo_level), 64'd0);
    check("rstm_done0", 64'(done_count), 64'd0);
    check("rstm_ready", 64'(in_ready), 64'd1);
    @(negedge clock);
    reset = 1'b1;
    base = n_issue;
    tick(10);
    check("rstm_no_issue", 64'(n_issue - base), 64'd0);
    check("rstm_idle",     64'(busy), 64'd0);
    check("rstm_lvl_post", 64'(fifo_level), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/element_update_feeder.md
Name: element_update_feeder

Overview:
Upstream feeder for the matrix solver core. Accepts host matrix-element update requests ({X, Y, NewElement}) over a valid/ready interface and buffers them in a FIFO. Issues them to the core one at a time: drives X/Y/NewElement, pulses EnableChange, then waits for the core's EOC_Flag rising edge before issuing the next. Also range-checks indices, detects core timeout and counts completions.

Parameters:
DEPTH, 8, FIFO entries (power of two, >=2)
MATRIX_N, 256, matrix dimension; legal indices are 0..MATRIX_N-1
TIMEOUT_CYCLES, 65535, max cycles to wait for EOC after an issue (>=4)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  reset; asynchronous, active-low
in_valid  input  1  host request valid
in_ready  output  1  feeder can accept a request
in_x  input  16  row index
in_y  input  16  column index
in_elem  input  48  element {real[47:24], imag[23:0]}, 24-bit floats, passed untouched
X  output  16  row index to core
Y  output  16  column index to core
NewElement  output  48  element to core
EnableChange  output  1  one-cycle issue strobe to core
EOC_Flag  input  1  core end-of-computation flag (level)
busy  output  1  an update is outstanding at the core
err_drop  output  1  one-cycle pulse: out-of-range request discarded
err_timeout  output  1  one-cycle pulse: core timed out
done_count  output  16  completed updates, wraps at 65535->0
fifo_level  output  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset=0, async): FIFO empty, state IDLE, X=Y=0, NewElement=0, EnableChange=0, busy=0, err_drop=0, err_timeout=0, done_count=0, fifo_level=0, eoc_q=0, timer=0. Reset mid-operation abandons the outstanding update and all queued entries.
- Host handshake: transfer when in_valid && in_ready. in_ready = !full (registered occupancy). No pass-through when full, even if a pop happens the same cycle.
- Range check at acceptance: if in_x >= MATRIX_N or in_y >= MATRIX_N, the request is consumed (handshake completes), not enqueued, err_drop=1 next cycle.
- Simultaneous push and pop: both happen; level unchanged. Pointers wrap modulo DEPTH.
- eoc_q registers EOC_Flag every cycle; eoc_rise = EOC_Flag && !eoc_q.
- FSM:
  IDLE: if FIFO not empty, pop the head; on the next edge, load X/Y/NewElement from it, set EnableChange=1, busy=1, timer=0, -> WAIT.
  WAIT: EnableChange=0 (strobe is exactly 1 cycle). X/Y/NewElement held stable. timer increments each cycle. eoc_rise on any cycle after the issue cycle -> done_count+1, busy=0, -> IDLE. An eoc_rise in the issue cycle itself is ignored. If timer reaches TIMEOUT_CYCLES with no eoc_rise -> err_timeout=1 for 1 cycle, busy=0, done_count unchanged, -> IDLE.
- eoc_rise and timeout in the same cycle: completion wins; no err_timeout.
- Issue throughput: back-to-back updates have at least 1 IDLE cycle between eoc_rise and the next EnableChange. Latency from an empty feeder to EnableChange: accept at cycle 0, EnableChange high at cycle 2.
- X/Y/NewElement change only on an issue edge; they hold their last values in IDLE.
- EOC_Flag high and never falling gives no new rise, so the next update times out (intended: protects against a stuck core).

Test Plan:
- Single update: push (x=3, y=5, elem=48'h3F8000_000000) into an empty feeder -> EnableChange high 1 cycle at cycle 2 with X=3, Y=5; EOC rises 10 cycles later -> busy falls, done_count=1.
- Fill: push 8 requests while EOC is withheld -> first issued, fifo_level reaches 7 then 8 at a further push, in_ready=0; release EOC -> entries issued in FIFO order, each exactly once, done_count=9 after all EOCs.
- Range: push x=256 (MATRIX_N=256) -> err_drop pulse, fifo_level unchanged, no EnableChange.
- Timeout: TIMEOUT_CYCLES=20, issue with no EOC -> err_timeout at wait cycle 20, busy=0, next queued entry issues, done_count unchanged.
- Race: eoc_rise on the exact timeout cycle -> done_count increments, no err_timeout. EOC held high across an issue -> timeout.
- Reset mid-WAIT with 3 queued -> all outputs return to 0 asynchronously; after release there are no issues without new pushes.
